// File: rtl/seq_pair_store_pkg.sv
// Shared definitions for the sequence pair store.
// Provides the default symbol width, the load/read FSM state type and a helper
// computing the index port width for a given maximum sequence length.
package seq_pair_store_pkg;

    // 3 bits covers DNA plus gap; protein builds use 5.
    localparam int unsigned SymWDefault = 3;

    // The gap symbol is always all-ones of the symbol width.
    localparam logic [SymWDefault-1:0] GapDefault = '1;

    typedef enum logic [1:0] {
        StIdle,
        StLoadA,
        StLoadB,
        StReady
    } state_e;

    // Index ports are [BitAddr:0] with BitAddr = $clog2(n+1).
    function automatic int unsigned idx_width(int unsigned n);
        return $clog2(n + 1) + 1;
    endfunction

endpackage

// File: rtl/seq_pair_store_bank.sv
// One sequence bank: N-deep symbol RAM plus length tracking.
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   clr            discard the current contents' length (new load begins)
//   wr, wr_last    accept wr_sym at the next address; wr_last commits the length
//   wr_sym         symbol to store
//   rd, rd_idx     registered read of address rd_idx (1..len valid)
//   len            committed length
//   ovf            combinational: this write was dropped because the bank is full
//   dout           read data, GAP for index 0 or beyond len, held when no read
//   idx_err        registered: last read index exceeded len
module seq_pair_store_bank
    import seq_pair_store_pkg::*;
#(
    parameter int unsigned N     = 128,
    parameter int unsigned SYM_W = SymWDefault,
    parameter int unsigned AW    = idx_width(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             wr,
    input  logic             wr_last,
    input  logic [SYM_W-1:0] wr_sym,
    input  logic             rd,
    input  logic [AW-1:0]    rd_idx,
    output logic [AW-1:0]    len,
    output logic             ovf,
    output logic [SYM_W-1:0] dout,
    output logic             idx_err
);

    localparam int unsigned      MW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [AW-1:0]    NMax = AW'(N);
    localparam logic [SYM_W-1:0] Gap  = '1;

    logic [SYM_W-1:0] mem [N];
    logic [AW-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]    len_q, len_d;
    logic [SYM_W-1:0] dout_q;
    logic             err_q;
    logic             full;
    logic             do_write;
    logic [AW-1:0]    rd_addr;
    logic             in_range;

    assign full     = (cnt_q == NMax);
    assign ovf      = wr & ~clr & full;
    assign do_write = wr & ~clr & ~full;

    always_comb begin
        cnt_d = cnt_q;
        len_d = len_q;
        if (clr) begin
            cnt_d = '0;
            len_d = '0;
        end else if (wr) begin
            if (!full) begin
                cnt_d = cnt_q + 1'b1;
            end
            // Overflowing symbols are dropped, so the committed length saturates at N.
            if (wr_last) begin
                len_d = full ? NMax : cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            len_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            len_q <= len_d;
        end
    end

    // Address k is stored at mem[k-1]; contents survive reset and reload.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[cnt_q[MW-1:0]] <= wr_sym;
        end
    end

    assign rd_addr  = rd_idx - 1'b1;
    assign in_range = (rd_idx != '0) && (rd_idx <= len_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout_q <= Gap;
            err_q  <= 1'b0;
        end else if (rd) begin
            dout_q <= in_range ? mem[rd_addr[MW-1:0]] : Gap;
            err_q  <= (rd_idx > len_q);
        end else begin
            err_q  <= 1'b0;
        end
    end

    assign len     = len_q;
    assign dout    = dout_q;
    assign idx_err = err_q;

endmodule

// File: rtl/seq_pair_store.sv
// Runtime-loaded store for the A and B sequences of the Needleman-Wunsch core.
// A streaming port loads A then B; a read port returns symbol pairs one cycle
// after the request with a valid strobe.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   load_start               restart loading: clear lengths, go to LOAD_A
//   ld_valid/ld_ready/ld_last/ld_sym   load stream handshake and data
//   len_a, len_b             committed sequence lengths
//   ready                    both sequences loaded, reads accepted
//   len_err                  sticky overflow flag
//   en_read, change_index, i, j        fill-phase read request
//   en_traceB, i_t, j_t      traceback read request (wins over en_read)
//   doutA, doutB, dout_valid read data and strobe
//   idx_err                  with dout_valid: an index exceeded its length
module seq_pair_store
    import seq_pair_store_pkg::*;
#(
    parameter int unsigned N       = 128,
    parameter int unsigned SYM_W   = SymWDefault,
    parameter int unsigned BitAddr = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_start,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic             ld_last,
    input  logic [SYM_W-1:0] ld_sym,
    output logic [BitAddr:0] len_a,
    output logic [BitAddr:0] len_b,
    output logic             ready,
    output logic             len_err,
    input  logic             en_read,
    input  logic             en_traceB,
    input  logic             change_index,
    input  logic [BitAddr:0] i,
    input  logic [BitAddr:0] j,
    input  logic [BitAddr:0] i_t,
    input  logic [BitAddr:0] j_t,
    output logic [SYM_W-1:0] doutA,
    output logic [SYM_W-1:0] doutB,
    output logic             dout_valid,
    output logic             idx_err
);

    localparam int unsigned AW = BitAddr + 1;

    state_e           state_q, state_d;
    logic             xfer;
    logic             wr_a, wr_b;
    logic             ovf_a, ovf_b;
    logic             err_a, err_b;
    logic             rd_issue;
    logic [AW-1:0]    idx_a, idx_b;
    logic             dout_valid_q;
    logic             len_err_q;

    assign ld_ready = (state_q == StLoadA) || (state_q == StLoadB);
    assign ready    = (state_q == StReady);
    assign xfer     = ld_valid & ld_ready;

    // A restart in the same cycle as a transfer discards that transfer.
    assign wr_a = xfer & (state_q == StLoadA) & ~load_start;
    assign wr_b = xfer & (state_q == StLoadB) & ~load_start;

    always_comb begin
        state_d = state_q;
        if (load_start) begin
            state_d = StLoadA;
        end else begin
            case (state_q)
                StLoadA: if (xfer && ld_last) state_d = StLoadB;
                StLoadB: if (xfer && ld_last) state_d = StReady;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Restart wins over a coincident read, so no result follows a load_start.
    assign rd_issue = ready & ~load_start & (en_traceB | (en_read & ~change_index));
    assign idx_a    = en_traceB ? i_t : i;
    assign idx_b    = en_traceB ? j_t : j;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout_valid_q <= 1'b0;
            len_err_q    <= 1'b0;
        end else begin
            dout_valid_q <= rd_issue;
            if (ovf_a || ovf_b) begin
                len_err_q <= 1'b1;
            end
        end
    end

    seq_pair_store_bank #(
        .N     (N),
        .SYM_W (SYM_W),
        .AW    (AW)
    ) u_bank_a (
        .clk     (clk),
        .rst     (rst),
        .clr     (load_start),
        .wr      (wr_a),
        .wr_last (ld_last),
        .wr_sym  (ld_sym),
        .rd      (rd_issue),
        .rd_idx  (idx_a),
        .len     (len_a),
        .ovf     (ovf_a),
        .dout    (doutA),
        .idx_err (err_a)
    );

    seq_pair_store_bank #(
        .N     (N),
        .SYM_W (SYM_W),
        .AW    (AW)
    ) u_bank_b (
        .clk     (clk),
        .rst     (rst),
        .clr     (load_start),
        .wr      (wr_b),
        .wr_last (ld_last),
        .wr_sym  (ld_sym),
        .rd      (rd_issue),
        .rd_idx  (idx_b),
        .len     (len_b),
        .ovf     (ovf_b),
        .dout    (doutB),
        .idx_err (err_b)
    );

    assign dout_valid = dout_valid_q;
    assign len_err    = len_err_q;
    // Bank error flags are only ever set by an issued read.
    assign idx_err    = err_a | err_b;

endmodule
